mem_model_slave: RTL and testbench

- Parametrised behavioural memory slave for the memory_interface protocol, for standalone bring-up of the matrix multiplier's load/store path on FPGA and in simulation.
- Generalises the fixed-pattern mock in four ways:
  - configurable data width;
  - configurable response latency;
  - selectable data mode (constant / address ramp / real RAM);
  - writes that actually store data.
- Sits at the memory side of memory_interface; the wrapper maps bus.clk, bus.reset_n, bus.req, bus.we, bus.addr, bus.wdata, bus.data and bus.ack onto the ports below.

---
 rtl/mem_model_pkg.sv | 28 ++
 rtl/mem_model_store.sv | 39 +++
 rtl/mem_model_slave.sv | 144 ++++++++++++++
 tb/tb_mem_model_slave.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_model_pkg.sv
// Shared types and helpers for the behavioural memory slave used in load/store bring-up.
package mem_model_pkg;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_RAM   = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Widest line the ramp helper can produce; callers slice down to their DATA_W.
  localparam int RAMP_MAX_W = 2048;

  function automatic logic [RAMP_MAX_W-1:0] ramp_line(input logic [7:0] base);
    logic [RAMP_MAX_W-1:0] line;
    line = '0;
    for (int i = 0; i < RAMP_MAX_W / 8; i++) begin
      line[i*8 +: 8] = base + 8'(i);
    end
    return line;
  endfunction

endpackage

// File: rtl/mem_model_store.sv
// Line storage: DEPTH x DATA_W array with per-line valid bits; sync write, comb read.
module mem_model_store
  import mem_model_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rline,
  output logic              o_rvalid
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_valid;

  // The array contents are deliberately left unreset; only validity is cleared.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_idx] <= 1'b1;
    end
  end

  assign o_rline  = r_mem[i_idx];
  assign o_rvalid = r_valid[i_idx];

endmodule

// File: rtl/mem_model_slave.sv
// Memory-side slave: req is held by the master until a one-cycle ack; busy spans acceptance
// through the ack cycle, and a req still high on the edge after ack starts a new transaction.
module mem_model_slave
  import mem_model_pkg::*;
#(
  parameter int         DATA_W    = 256,
  parameter int         ADDR_W    = 32,
  parameter int         DEPTH     = 64,
  parameter int         LATENCY   = 1,
  parameter mode_e      MODE      = MODE_RAM,
  parameter logic [7:0] FILL_BYTE = 8'h01
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] data,
  output logic              ack,
  output logic              busy,
  output state_e            dbg_state
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_model_slave: LATENCY must be in 1..15");
  end
  if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > RAMP_MAX_W) begin : g_bad_width
    $error("mem_model_slave: DATA_W must be a multiple of 8 within the ramp helper range");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mem_model_slave: DEPTH must be a power of 2");
  end
  if (ADDR_W < 8 || ADDR_W < OFF_W + IDX_W) begin : g_bad_addr
    $error("mem_model_slave: ADDR_W too narrow for the line index");
  end

  state_e              r_state;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_data;
  logic                r_ack;
  logic                r_busy;

  logic [IDX_W-1:0]      w_idx;
  logic                  w_access;
  logic                  w_st_we;
  logic [DATA_W-1:0]     w_line;
  logic                  w_line_valid;
  logic [RAMP_MAX_W-1:0] w_ramp_full;
  logic [DATA_W-1:0]     w_ramp;
  logic [DATA_W-1:0]     w_rd_data;
  logic                  w_unused;

  assign w_idx       = r_addr[OFF_W +: IDX_W];
  assign w_access    = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_st_we     = w_access && r_we && (MODE == MODE_RAM);
  assign w_ramp_full = ramp_line(r_addr[7:0]);
  assign w_ramp      = w_ramp_full[DATA_W-1:0];
  assign w_unused    = ^{r_addr, w_ramp_full};

  mem_model_store #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_store (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_we     (w_st_we),
    .i_idx    (w_idx),
    .i_wdata  (r_wdata),
    .o_rline  (w_line),
    .o_rvalid (w_line_valid)
  );

  // Unwritten RAM lines fall back to the ramp so reads are never undefined.
  always_comb begin
    w_rd_data = w_ramp;
    case (MODE)
      MODE_CONST: w_rd_data = {(DATA_W / 8){FILL_BYTE}};
      MODE_RAMP:  w_rd_data = w_ramp;
      default:    w_rd_data = w_line_valid ? w_line : w_ramp;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_data  <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= ACK;
            r_ack   <= 1'b1;
            if (!r_we) begin
              r_data <= w_rd_data;
            end
          end
        end
        // The ACK cycle's closing edge doubles as the first IDLE edge, so a held
        // req is accepted there and back-to-back spacing stays LATENCY+1.
        IDLE, ACK: begin
          r_ack <= 1'b0;
          if (req) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_cnt   <= 4'(LATENCY - 1);
            r_busy  <= 1'b1;
            r_state <= WAIT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_ack   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign data      = r_data;
  assign ack       = r_ack;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_model_slave.sv
// Randomised scoreboard bench for mem_model_slave across const/ramp/RAM modes and latencies.
`timescale 1ns/1ps
module tb_mem_model_slave;
  import mem_model_pkg::*;

  localparam int DW = 256;
  localparam int NB = DW / 8;
  localparam int NI = 4;
  localparam int LAT   [NI] = '{1, 3, 2, 4};
  localparam int MODEV [NI] = '{0, 1, 2, 2};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n [NI];
  logic          req   [NI];
  logic          we    [NI];
  logic [31:0]   addr  [NI];
  logic [DW-1:0] wdata [NI];
  logic [DW-1:0] data  [NI];
  logic          ack   [NI];
  logic          busy  [NI];
  state_e        dbg   [NI];

  mem_model_slave #(.DATA_W(DW), .ADDR_W(32), .DEPTH(64), .LATENCY(1),
                    .MODE(MODE_CONST), .FILL_BYTE(8'h01)) u_const (
    .clk(clk), .reset_n(rst_n[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .data(data[0]), .ack(ack[0]), .busy(busy[0]), .dbg_state(dbg[0]));

  mem_model_slave #(.DATA_W(DW), .ADDR_W(32), .DEPTH(64), .LATENCY(3),
                    .MODE(MODE_RAMP), .FILL_BYTE(8'h01)) u_ramp (
    .clk(clk), .reset_n(rst_n[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .data(data[1]), .ack(ack[1]), .busy(busy[1]), .dbg_state(dbg[1]));

  mem_model_slave #(.DATA_W(DW), .ADDR_W(32), .DEPTH(64), .LATENCY(2),
                    .MODE(MODE_RAM), .FILL_BYTE(8'h01)) u_ram2 (
    .clk(clk), .reset_n(rst_n[2]), .req(req[2]), .we(we[2]), .addr(addr[2]),
    .wdata(wdata[2]), .data(data[2]), .ack(ack[2]), .busy(busy[2]), .dbg_state(dbg[2]));

  mem_model_slave #(.DATA_W(DW), .ADDR_W(32), .DEPTH(64), .LATENCY(4),
                    .MODE(MODE_RAM), .FILL_BYTE(8'h01)) u_ram4 (
    .clk(clk), .reset_n(rst_n[3]), .req(req[3]), .we(we[3]), .addr(addr[3]),
    .wdata(wdata[3]), .data(data[3]), .ack(ack[3]), .busy(busy[3]), .dbg_state(dbg[3]));

  // ---------------- scoreboard and reference model ----------------
  int total = 0;
  int bad   = 0;
  logic [DW+1:0] exp_q [$];
  logic [DW+1:0] mon_e;
  logic          prev_ack [NI];

  logic [DW-1:0] m_mem  [NI][64];
  logic          m_vld  [NI][64];
  logic [DW-1:0] m_last [NI];

  logic [31:0]   op_a [$];
  bit            op_w [$];
  logic [DW-1:0] op_d [$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ramp_ref(input logic [31:0] a);
    logic [DW-1:0] r;
    for (int i = 0; i < NB; i++) begin
      r[i*8 +: 8] = 8'((int'(a % 256) + i) % 256);
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic void model_reset(input int inst);
    for (int i = 0; i < 64; i++) m_vld[inst][i] = 1'b0;
    m_last[inst] = '0;
  endfunction

  // Returns the data value the slave should present at the ack of this transaction.
  function automatic logic [DW-1:0] model_txn(input int inst, input bit w,
                                              input logic [31:0] a, input logic [DW-1:0] wd);
    int idx;
    idx = int'((a / 32) % 64);
    if (w) begin
      if (MODEV[inst] == 2) begin
        m_mem[inst][idx] = wd;
        m_vld[inst][idx] = 1'b1;
      end
    end else begin
      case (MODEV[inst])
        0:       m_last[inst] = {NB{8'h01}};
        1:       m_last[inst] = ramp_ref(a);
        default: m_last[inst] = m_vld[inst][idx] ? m_mem[inst][idx] : ramp_ref(a);
      endcase
    end
    return m_last[inst];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_op(input bit w, input logic [31:0] a, input logic [DW-1:0] d);
    op_w.push_back(w);
    op_a.push_back(a);
    op_d.push_back(d);
  endtask

  task automatic run_ops(input int inst, input bit b2b);
    bit            w;
    logic [31:0]   a;
    logic [DW-1:0] d;
    int            n;
    int            gap;
    bit            got;
    while (op_a.size() != 0) begin
      w = op_w.pop_front();
      a = op_a.pop_front();
      d = op_d.pop_front();
      exp_q.push_back({2'(inst), model_txn(inst, w, a, d)});
      req[inst]   = 1'b1;
      we[inst]    = w;
      addr[inst]  = a;
      wdata[inst] = d;
      n   = 0;
      got = 1'b0;
      while (!got && n < 40) begin
        @(negedge clk);
        n++;
        if (ack[inst]) begin
          got = 1'b1;
        end else begin
          chk("busy_wait", DW'(busy[inst]), DW'(1));
          if (n == 1) begin
            we[inst]    = ~w;
            addr[inst]  = $urandom();
            wdata[inst] = rand_line();
          end
        end
      end
      chk("ack_latency", DW'(n), DW'(LAT[inst] + 1));
      if (got) chk("busy_at_ack", DW'(busy[inst]), DW'(1));
      if (!b2b || op_a.size() == 0) begin
        req[inst] = 1'b0;
        we[inst]  = 1'b0;
        gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk("idle_busy", DW'(busy[inst]), DW'(0));
          chk("idle_ack", DW'(ack[inst]), DW'(0));
        end
      end
    end
  endtask

  task automatic rand_ops(input int inst, input int cnt, input bit b2b);
    for (int k = 0; k < cnt; k++) begin
      push_op(1'($urandom_range(0, 1)),
              ($urandom() & 32'hFFFF_F800) | 32'($urandom_range(0, 255)), rand_line());
    end
    run_ops(inst, b2b);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst_n[i] === 1'b1 && ack[i] === 1'b1) begin
        chk("ack_single_cycle", DW'(prev_ack[i]), DW'(0));
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack @%0t: inst %0d got ack want none", $time, i);
        end else begin
          mon_e = exp_q.pop_front();
          chk("resp_inst", DW'(mon_e[DW+1:DW]), DW'(i));
          chk("resp_data", data[i], mon_e[DW-1:0]);
        end
      end
      prev_ack[i] = ack[i];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0;
      addr[i] = '0; wdata[i] = '0; prev_ack[i] = 1'b0;
      model_reset(i);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        chk("reset_ack", DW'(ack[i]), DW'(0));
        chk("reset_busy", DW'(busy[i]), DW'(0));
        chk("reset_data", data[i], '0);
      end
    end
    for (int i = 0; i < NI; i++) chk("reset_state", DW'(dbg[i]), DW'(IDLE));

    // Constant mode, latency 1
    push_op(1'b0, 32'h40, rand_line());
    run_ops(0, 1'b0);
    chk("const_line", data[0], {NB{8'h01}});
    rand_ops(0, 20, 1'b1);

    // Ramp mode, latency 3, including byte wrap
    push_op(1'b0, 32'h20, '0);
    run_ops(1, 1'b0);
    chk("ramp20_b0", DW'(data[1][7:0]), DW'(8'h20));
    chk("ramp20_b31", DW'(data[1][255:248]), DW'(8'h3F));
    push_op(1'b0, 32'hF0, '0);
    run_ops(1, 1'b0);
    chk("rampF0_b15", DW'(data[1][127:120]), DW'(8'hFF));
    chk("rampF0_b16", DW'(data[1][135:128]), DW'(8'h00));
    rand_ops(1, 20, 1'b0);

    // RAM mode: unwritten line, write then back-to-back read, aliased index
    push_op(1'b0, 32'hA0, '0);
    run_ops(2, 1'b0);
    chk("ram_unwritten_b0", DW'(data[2][7:0]), DW'(8'hA0));
    push_op(1'b1, 32'hA0, {NB{8'hA5}});
    push_op(1'b0, 32'hA0, '0);
    run_ops(2, 1'b1);
    chk("ram_rdback", data[2], {NB{8'hA5}});
    push_op(1'b0, 32'hA0 + 32'(64 * 32), '0);
    run_ops(2, 1'b0);
    chk("ram_alias", data[2], {NB{8'hA5}});

    // req held high continuously: one ack every LATENCY+1 cycles
    for (int k = 0; k < 4; k++) exp_q.push_back({2'd2, model_txn(2, 1'b0, 32'h133, '0)});
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h133;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      chk("hold_ack", DW'(ack[2]), DW'((n % 3) == 0));
      if (n == 12) req[2] = 1'b0;
    end
    @(negedge clk);
    chk("hold_busy_end", DW'(busy[2]), DW'(0));

    rand_ops(2, 40, 1'b1);
    rand_ops(2, 40, 1'b0);

    // Reset mid-operation on the latency-4 RAM instance
    push_op(1'b1, 32'h20, rand_line());
    push_op(1'b0, 32'h20, '0);
    run_ops(3, 1'b0);
    req[3] = 1'b1; we[3] = 1'b1; addr[3] = 32'h0; wdata[3] = {NB{8'h5A}};
    @(negedge clk);
    @(negedge clk);
    rst_n[3] = 1'b0; req[3] = 1'b0; we[3] = 1'b0;
    model_reset(3);
    @(negedge clk);
    chk("midrst_busy", DW'(busy[3]), DW'(0));
    chk("midrst_data", data[3], '0);
    chk("midrst_state", DW'(dbg[3]), DW'(IDLE));
    rst_n[3] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("midrst_no_ack", DW'(ack[3]), DW'(0));
    end
    push_op(1'b0, 32'h00, '0);
    push_op(1'b0, 32'h20, '0);
    run_ops(3, 1'b0);
    chk("midrst_valid_cleared_b0", DW'(data[3][7:0]), DW'(8'h20));
    rand_ops(3, 16, 1'b1);

    repeat (5) @(negedge clk);
    chk("queue_drained", DW'(exp_q.size()), DW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
